reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   8x8 register file for the simple processor datapath. It feeds the two ALU
//   operand buses (DATA1/DATA2) from two combinational read ports. It accepts
//   the ALU RESULT back on one synchronous write port. WRITE_DONE is a one-cycle
//   commit pulse so the control unit can sequence dependent instructions.
// PARAMETERS
//   DATA_W       8   register / bus width; equals ALU operand width
//   ADDR_W       3   address width; DEPTH = 2**ADDR_W = 8 registers
//   READ_DELAY   2   model delay (time units) from address/data change to OUT1/OUT2
//   WRITE_DELAY  1   model delay (time units) from CLK posedge to register update
//   BYPASS       0   1: a read of the address being written returns IN in the same cycle
// PORTS
//   CLK          in   1       clock; all state changes on the rising edge
//   RESET        in   1       synchronous, active-high; clears all registers
//   IN           in   DATA_W  write data, driven from ALU RESULT
//   INADDRESS    in   ADDR_W  destination register
//   WRITE        in   1       write enable, sampled at CLK posedge
//   OUT1ADDRESS  in   ADDR_W  read port 1 address
//   OUT2ADDRESS  in   ADDR_W  read port 2 address
//   OUT1         out  DATA_W  read port 1 data, to ALU DATA1
//   OUT2         out  DATA_W  read port 2 data, to ALU DATA2
//   WRITE_DONE   out  1       registered pulse, high one cycle after a committed write
// BEHAVIOUR
//   - State: reg[0..DEPTH-1] (DATA_W each); WRITE_DONE flop. No register is hardwired to 0.
//   - Reset: at a posedge with RESET=1, all registers become 0 after WRITE_DELAY.
//     WRITE_DONE becomes 0. RESET overrides WRITE in the same cycle; that write is lost.
//   - Reset mid-operation: the reset cycle discards any write. Writes resume on the
//     first posedge with RESET=0.
//   - Write: at a posedge with RESET=0 and WRITE=1, reg[INADDRESS] <= IN after WRITE_DELAY.
//     At that posedge, WRITE_DONE <= 1. At a posedge with RESET=0 and WRITE=0,
//     WRITE_DONE <= 0 and no register changes.
//   - WRITE_DONE: exactly one cycle high per committed write. Back-to-back writes
//     hold it high for consecutive cycles.
//   - Read: OUTn = reg[OUTnADDRESS], combinational, settled READ_DELAY after any
//     change of the address or of the addressed register. No clock is involved.
//   - Dual read: both ports may address the same register; both return the same value.
//   - Read of the register being written:
//     BYPASS=0: old value until the commit, new value READ_DELAY after the commit.
//     BYPASS=1: while WRITE=1, RESET=0 and OUTnADDRESS==INADDRESS, OUTn = IN
//     (after READ_DELAY); after the commit it returns the stored value, which equals IN.
//   - Width: no arithmetic is performed. IN is stored unmodified. All addresses are
//     in range (DEPTH = 2**ADDR_W).
//   - X on INADDRESS while WRITE=1 has no defined result; the bench does not drive it.
//   - Latency: write-to-visible = WRITE_DELAY + READ_DELAY after the posedge
//     (3 time units at defaults). Read = READ_DELAY.
// TESTING
//   1. Reset: write 8'hAA to r5, then RESET=1 for one cycle.
//      -> OUT1 (addr 5) = 8'h00, every register reads 0, WRITE_DONE=0.
//   2. Write/read: WRITE=1, INADDRESS=3, IN=8'h2C for one posedge; OUT1ADDRESS=3, OUT2ADDRESS=3.
//      -> both outputs 8'h2C 3 time units after the edge; WRITE_DONE=1 for exactly one cycle.
//   3. Back-to-back: write r0=8'h01, r1=8'h02, r7=8'hFF on consecutive cycles.
//      -> WRITE_DONE high 3 cycles; read-back 01/02/FF; r2..r6 still 0.
//   4. Same-cycle read/write, BYPASS=0: r4=8'h10, then write r4=8'h20 while OUT1ADDRESS=4.
//      -> OUT1=8'h10 before the edge, 8'h20 after. With BYPASS=1 -> OUT1=8'h20 within
//      READ_DELAY of IN/WRITE settling.
//   5. Reset vs write collision: RESET=1 and WRITE=1, INADDRESS=6, IN=8'h55 on one edge.
//      -> r6=8'h00, WRITE_DONE=0.
//   6. ALU loop: r1=8'h05, r2=8'h03; OUT1->DATA1, OUT2->DATA2, SELECT=ADD; RESULT->IN,
//      write r3.
//      -> r3 reads 8'h08; repeat with SELECT=AND -> 8'h01.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 8x8 register file for the processor datapath.
// Two combinational read ports feed the ALU operand buses; one synchronous
// write port takes the ALU result back. WRITE_DONE pulses for one cycle after
// each committed write so the control unit can sequence dependent instructions.
// READ_DELAY / WRITE_DELAY describe the timing of the behavioural model this
// block replaces; the synthesized logic settles within the clock period.
module reg_file #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1,
    parameter bit BYPASS      = 1'b0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              WRITE_DONE
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The delay figures are only meaningful as non-negative model times.
    generate
        if (READ_DELAY < 0 || WRITE_DELAY < 0) begin : g_bad_delay
            $error("reg_file: model delays must be non-negative");
        end
    endgenerate

    logic [DATA_W-1:0] regs [DEPTH];
    logic              fwd1;
    logic              fwd2;

    // Register array and commit pulse; reset wins over a same-cycle write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            WRITE_DONE <= 1'b0;
        end else begin
            if (WRITE) begin
                regs[INADDRESS] <= IN;
            end
            WRITE_DONE <= WRITE;
        end
    end

    // Combinational read ports, optionally forwarding the pending write data.
    always_comb begin
        fwd1 = BYPASS && WRITE && !RESET && (OUT1ADDRESS == INADDRESS);
        fwd2 = BYPASS && WRITE && !RESET && (OUT2ADDRESS == INADDRESS);
        OUT1 = fwd1 ? IN : regs[OUT1ADDRESS];
        OUT2 = fwd2 ? IN : regs[OUT2ADDRESS];
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed vectors for reg_file, with a bypass instance alongside.
module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] a1;
    logic [2:0] a2;
    logic       use_alu;
    logic       alu_and;
    logic [7:0] alu_result;
    logic [7:0] in_bus;

    logic [7:0] o1_nb, o2_nb, o1_bp, o2_bp;
    logic       done_nb, done_bp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Bench-side ALU closing the datapath loop (stimulus only).
    assign alu_result = alu_and ? (o1_nb & o2_nb) : (o1_nb + o2_nb);
    assign in_bus     = use_alu ? alu_result : wdata;

    reg_file #(.BYPASS(1'b0)) dut_nb (
        .CLK(clk), .RESET(rst), .IN(in_bus), .INADDRESS(waddr), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2),
        .OUT1(o1_nb), .OUT2(o2_nb), .WRITE_DONE(done_nb)
    );

    reg_file #(.BYPASS(1'b1)) dut_bp (
        .CLK(clk), .RESET(rst), .IN(in_bus), .INADDRESS(waddr), .WRITE(wr),
        .OUT1ADDRESS(a1), .OUT2ADDRESS(a2),
        .OUT1(o1_bp), .OUT2(o2_bp), .WRITE_DONE(done_bp)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [2:0] waddr;
        logic [7:0] wdata;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
        logic       edone;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] wa,
                                input logic [7:0] wd, input logic [2:0] ra1,
                                input logic [2:0] ra2, input logic [7:0] x1,
                                input logic [7:0] x2, input logic xd);
        vec_t v;
        v.rst = r; v.wr = w; v.waddr = wa; v.wdata = wd;
        v.a1 = ra1; v.a2 = ra2; v.e1 = x1; v.e2 = x2; v.edone = xd;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                         input logic [7:0] wd, input logic [2:0] ra1, input logic [2:0] ra2);
        rst = r; wr = w; waddr = wa; wdata = wd; a1 = ra1; a2 = ra2;
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
        use_alu = 1'b0;
        alu_and = 1'b0;

        // Each vector: inputs held across one posedge, outputs checked 4 units later.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0)); // initial reset
        vecs.push_back(mk(0, 1, 5, 8'hAA, 5, 0, 8'hAA, 8'h00, 1)); // r5 = AA
        vecs.push_back(mk(1, 0, 0, 8'h00, 5, 5, 8'h00, 8'h00, 0)); // reset clears r5
        vecs.push_back(mk(0, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2, 3, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4, 5, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 6, 7, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 1, 3, 8'h2C, 3, 3, 8'h2C, 8'h2C, 1)); // r3 = 2C, dual read
        vecs.push_back(mk(0, 0, 3, 8'h2C, 3, 3, 8'h2C, 8'h2C, 0)); // pulse is one cycle
        vecs.push_back(mk(0, 1, 0, 8'h01, 0, 3, 8'h01, 8'h2C, 1)); // back-to-back
        vecs.push_back(mk(0, 1, 1, 8'h02, 1, 0, 8'h02, 8'h01, 1));
        vecs.push_back(mk(0, 1, 7, 8'hFF, 7, 1, 8'hFF, 8'h02, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 2, 6, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4, 5, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 7, 0, 8'hFF, 8'h01, 0));
        vecs.push_back(mk(1, 1, 6, 8'h55, 6, 7, 8'h00, 8'h00, 0)); // reset beats write
        vecs.push_back(mk(0, 0, 6, 8'h55, 6, 3, 8'h00, 8'h00, 0)); // write was lost
        vecs.push_back(mk(0, 1, 6, 8'h55, 6, 0, 8'h55, 8'h00, 1)); // writes resume
        vecs.push_back(mk(0, 0, 0, 8'h00, 6, 6, 8'h55, 8'h55, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].a1, vecs[i].a2);
            @(posedge clk);
            #4;
            check($sformatf("vec%0d out1", i), o1_nb, vecs[i].e1);
            check($sformatf("vec%0d out2", i), o2_nb, vecs[i].e2);
            check($sformatf("vec%0d write_done", i), {7'b0, done_nb}, {7'b0, vecs[i].edone});
            check($sformatf("vec%0d bp_write_done", i), {7'b0, done_bp}, {7'b0, vecs[i].edone});
        end

        // Same-cycle read/write of r4, with and without bypass.
        drive(1'b0, 1'b1, 3'd4, 8'h10, 3'd4, 3'd4);
        @(posedge clk);
        #4;
        drive(1'b0, 1'b1, 3'd4, 8'h20, 3'd4, 3'd2);
        #3;
        check("rw nobypass before edge", o1_nb, 8'h10);
        check("rw bypass before edge", o1_bp, 8'h20);
        check("rw bypass other port", o2_bp, 8'h00);
        @(posedge clk);
        #4;
        check("rw nobypass after edge", o1_nb, 8'h20);
        check("rw bypass after edge", o1_bp, 8'h20);
        drive(1'b0, 1'b0, 3'd4, 8'h00, 3'd4, 3'd4);
        #2;
        check("rw bypass stored", o1_bp, 8'h20);
        check("rw bypass off when idle", o2_bp, 8'h20);

        // Bypass must not forward while reset is asserted.
        drive(1'b1, 1'b1, 3'd4, 8'h77, 3'd4, 3'd4);
        #2;
        check("bypass blocked by reset", o1_bp, 8'h20);
        @(posedge clk);
        #4;
        check("reset clears r4", o1_nb, 8'h00);

        // ALU loop: r1=05, r2=03, r3 = r1 + r2, then r3 = r1 & r2.
        drive(1'b0, 1'b1, 3'd1, 8'h05, 3'd0, 3'd0);
        @(posedge clk);
        #4;
        drive(1'b0, 1'b1, 3'd2, 8'h03, 3'd0, 3'd0);
        @(posedge clk);
        #4;
        drive(1'b0, 1'b1, 3'd3, 8'h00, 3'd1, 3'd2);
        use_alu = 1'b1;
        alu_and = 1'b0;
        @(posedge clk);
        #4;
        use_alu = 1'b0;
        drive(1'b0, 1'b0, 3'd3, 8'h00, 3'd3, 3'd2);
        #3;
        check("alu add r3", o1_nb, 8'h08);
        drive(1'b0, 1'b1, 3'd3, 8'h00, 3'd1, 3'd2);
        use_alu = 1'b1;
        alu_and = 1'b1;
        @(posedge clk);
        #4;
        use_alu = 1'b0;
        drive(1'b0, 1'b0, 3'd3, 8'h00, 3'd3, 3'd1);
        #3;
        check("alu and r3", o1_nb, 8'h01);
        check("alu r1 kept", o2_nb, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
